// File: rtl/obuf_reader_if.sv
// Output stream bundle of the output-buffer reader.
// A beat transfers on every rising clock edge where valid and ready are both 1.
// While valid=1 and ready=0, the master holds data and last stable.
interface obuf_reader_if #(
  parameter int VEC_WIDTH = 64
);
  logic [VEC_WIDTH-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/obuf_reader.sv
// Read-side engine for the INT4x16 output buffer: reads num words from address 0
// and streams them out through a 2-entry fall-through FIFO that absorbs RAM latency.
module obuf_reader #(
  parameter int VEC_WIDTH = 64,
  parameter int ARR_DEPTH = 64,
  parameter int ADDR_W    = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [ADDR_W:0]      i_num,
  output logic                 o_ram_re,
  output logic [ADDR_W-1:0]    o_ram_addr,
  input  logic [VEC_WIDTH-1:0] i_ram_data,
  obuf_reader_if.master        out_if,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [1:0]           o_state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_W:0]      num_q, num_d;
  logic [ADDR_W:0]      issued_q, issued_d;
  logic [ADDR_W:0]      sent_q, sent_d;
  logic [ADDR_W-1:0]    rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]    ram_addr_q, ram_addr_d;
  logic                 inflight_q, inflight_d;
  logic [VEC_WIDTH-1:0] fifo_q [2];
  logic                 wr_ptr_q, rd_ptr_q;
  logic [1:0]           count_q, count_d;

  logic                 valid;
  logic                 pop;
  logic                 pop_fifo;
  logic                 push;
  logic                 issue;
  logic [1:0]           occ;
  logic [1:0]           occ_after_pop;

  // Fall-through: with an empty FIFO the in-flight RAM word is presented directly,
  // which gives first data two cycles after start.
  assign valid = (count_q != 2'd0) || inflight_q;
  assign pop   = valid && out_if.ready;

  always_comb begin
    out_if.data = '0;
    if (count_q != 2'd0) begin
      out_if.data = fifo_q[rd_ptr_q];
    end else if (inflight_q) begin
      out_if.data = i_ram_data;
    end
  end

  assign out_if.valid = valid;
  assign out_if.last  = valid && (sent_q == (num_q - (ADDR_W+1)'(1)));

  // A word that arrives into an empty FIFO and is taken immediately is never stored.
  assign pop_fifo = pop && (count_q != 2'd0);
  assign push     = inflight_q && ((count_q != 2'd0) || !pop);

  // Credit: buffered plus in-flight words, after this cycle's pop, must leave room.
  assign occ           = count_q + {1'b0, inflight_q};
  assign occ_after_pop = occ - {1'b0, pop};
  assign issue         = (state_q == S_READ) && (issued_q < num_q) && (occ_after_pop < 2'd2);

  assign o_ram_re    = issue;
  assign o_ram_addr  = issue ? rd_addr_q : ram_addr_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = (state_q == S_DONE);
  assign o_state_dbg = state_q;

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    issued_d   = issued_q + (ADDR_W+1)'(issue);
    sent_d     = sent_q + (ADDR_W+1)'(pop);
    rd_addr_d  = rd_addr_q + ADDR_W'(issue);
    ram_addr_d = issue ? rd_addr_q : ram_addr_q;
    inflight_d = issue;
    count_d    = count_q + 2'(push) - 2'(pop_fifo);
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          num_d     = i_num;
          issued_d  = '0;
          sent_d    = '0;
          rd_addr_d = '0;
          state_d   = (i_num == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (issued_d == num_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (sent_d == num_q) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      num_q      <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      rd_addr_q  <= '0;
      ram_addr_q <= '0;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      issued_q   <= issued_d;
      sent_q     <= sent_d;
      rd_addr_q  <= rd_addr_d;
      ram_addr_q <= ram_addr_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= i_ram_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_fifo) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      assert (!(push && !pop_fifo && (count_q == 2'd2)));
      if ((state_q == S_IDLE) && i_start) begin
        assert (i_num <= (ADDR_W+1)'(ARR_DEPTH));
      end
    end
  end

endmodule

// File: tb/tb_obuf_reader.sv
// Bench for obuf_reader: RAM model, spec-level stream model (expected word queue,
// latency arithmetic, credit bound) and directed plus randomized transfers.
module tb_obuf_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [6:0]  num_in;
  logic        ram_re;
  logic [5:0]  ram_addr;
  logic [63:0] ram_data = '0;
  logic        busy;
  logic        done;
  logic [1:0]  state_dbg;

  logic [63:0] mem [64];
  logic [63:0] exp_q [$];

  int errors = 0;
  int checks = 0;

  obuf_reader_if #(.VEC_WIDTH(64)) bus ();

  obuf_reader #(.VEC_WIDTH(64), .ARR_DEPTH(64), .ADDR_W(6)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_num       (num_in),
    .o_ram_re    (ram_re),
    .o_ram_addr  (ram_addr),
    .i_ram_data  (ram_data),
    .out_if      (bus.master),
    .o_busy      (busy),
    .o_done      (done),
    .o_state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // single-port RAM with one cycle of read latency
  always_ff @(posedge clk) begin
    if (ram_re) ram_data <= mem[ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_re"},    64'(ram_re),    64'd0);
    chk({tag, "_addr"},  64'(ram_addr),  64'd0);
    chk({tag, "_data"},  bus.data,       64'd0);
    chk({tag, "_valid"}, 64'(bus.valid), 64'd0);
    chk({tag, "_last"},  64'(bus.last),  64'd0);
    chk({tag, "_busy"},  64'(busy),      64'd0);
    chk({tag, "_done"},  64'(done),      64'd0);
    chk({tag, "_state"}, 64'(state_dbg), 64'd0);
  endtask

  // mode 0: ready held high, exact latency checked; mode 1: random ready with a 5-cycle stall.
  // restart_at: cycle to pulse a second start (num=2); reset_at: cycle to assert reset.
  task automatic run_xfer(input int num, input int mode, input int restart_at, input int reset_at);
    int          c;
    int          beats;
    int          reads;
    int          done_cyc;
    int          last_acc;
    logic        acc;
    logic        aborted;
    logic        prev_stall;
    logic [63:0] prev_data;
    logic        prev_last;

    exp_q.delete();
    for (int i = 0; i < num; i++) exp_q.push_back(mem[i]);

    start  = 1'b1;
    num_in = 7'(num);
    bus.ready = 1'b1;
    #1;
    chk("start_idle_busy",  64'(busy),      64'd0);
    chk("start_idle_valid", 64'(bus.valid), 64'd0);
    tick();

    c = 1; beats = 0; reads = 0; done_cyc = -1; last_acc = -1;
    aborted = 1'b0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    while (done_cyc < 0 && c < 400) begin
      if (mode == 1) bus.ready = (c >= 4 && c < 9) ? 1'b0 : 1'($urandom_range(0, 1));
      else           bus.ready = 1'b1;
      if (c == restart_at) begin
        start  = 1'b1;
        num_in = 7'd2;
      end else begin
        start = 1'b0;
      end
      if (c == reset_at) begin
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        tick();
        tick();
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        aborted = 1'b1;
        break;
      end
      #1;
      acc = bus.valid && bus.ready;

      if (ram_re) begin
        chk("rd_addr", 64'(ram_addr), 64'(reads));
        reads++;
        chk("no_extra_read", 64'(reads <= num), 64'd1);
      end
      chk("credit", 64'((reads - beats - int'(acc)) <= 2), 64'd1);
      chk("busy_during", 64'(busy), 64'd1);

      if (prev_stall) begin
        chk("stall_valid", 64'(bus.valid), 64'd1);
        chk("stall_data",  bus.data,        prev_data);
        chk("stall_last",  64'(bus.last),   64'(prev_last));
      end

      if (bus.valid) begin
        chk("extra_beat", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) chk("beat_data", bus.data, exp_q[0]);
        chk("beat_last", 64'(bus.last), 64'(beats == num - 1));
      end else begin
        chk("last_idle", 64'(bus.last), 64'd0);
      end

      if (mode == 0) begin
        chk("re_timing",    64'(ram_re),    64'(c >= 1 && c <= num));
        chk("valid_timing", 64'(bus.valid), 64'(c >= 2 && c <= num + 1));
      end

      if (acc) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        beats++;
        last_acc = c;
      end

      if (done) begin
        done_cyc = c;
        if (num == 0) chk("done_num0", 64'(c), 64'd1);
        else          chk("done_after_last", 64'(c), 64'(last_acc + 1));
      end

      prev_stall = bus.valid && !bus.ready;
      prev_data  = bus.data;
      prev_last  = bus.last;
      tick();
      c++;
    end
    start = 1'b0;

    if (!aborted) begin
      chk("done_seen", 64'(done_cyc >= 0), 64'd1);
      chk("beat_count", 64'(beats), 64'(num));
      chk("read_count", 64'(reads), 64'(num));
      if (mode == 0) chk("done_timing", 64'(done_cyc), (num == 0) ? 64'd1 : 64'(num + 2));
      #1;
      chk("busy_after_done", 64'(busy), 64'd0);
      chk("done_pulse",      64'(done), 64'd0);
      tick();
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom};
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    num_in    = '0;
    bus.ready = 1'b0;
    fill_random();
    #22;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
    tick();

    run_xfer(4, 0, -1, -1);

    for (int i = 0; i < 64; i++) mem[i] = 64'(i) * 64'h0101010101010101;
    run_xfer(64, 0, -1, -1);

    fill_random();
    run_xfer(8, 1, -1, -1);

    run_xfer(0, 0, 1, -1);

    run_xfer(4, 0, 3, -1);

    fill_random();
    run_xfer(16, 0, -1, 3);
    run_xfer(2, 0, -1, -1);

    for (int k = 0; k < 3; k++) begin
      fill_random();
      run_xfer($urandom_range(1, 64), 1, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
